// File: rtl/bus_addr_ctrl.sv
// Off-chip address-phase controller: round-robin arbitration between the
// instruction-fetch and load/store ports, a programmable address hold and a done pulse.
module bus_addr_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WAIT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_gnt,
  output logic              imem_done,
  input  logic              dmem_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_gnt,
  output logic              dmem_done,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_valid_o,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_last_dmem;
  logic              r_owner_dmem;
  logic              w_win_dmem;

  // On a tie the port that did not win last time takes the bus.
  assign w_win_dmem  = dmem_req & (~imem_req | ~r_last_dmem);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_dmem  <= 1'b0;
      r_owner_dmem <= 1'b0;
      bus_addr_o   <= '0;
      bus_valid_o  <= 1'b0;
      busy         <= 1'b0;
      imem_gnt     <= 1'b0;
      dmem_gnt     <= 1'b0;
      imem_done    <= 1'b0;
      dmem_done    <= 1'b0;
    end else begin
      imem_gnt  <= 1'b0;
      dmem_gnt  <= 1'b0;
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (imem_req | dmem_req) begin
            r_state      <= S_ADDR;
            r_cnt        <= wait_cfg;
            bus_addr_o   <= w_win_dmem ? dmem_addr : imem_addr;
            bus_valid_o  <= 1'b1;
            busy         <= 1'b1;
            r_owner_dmem <= w_win_dmem;
            r_last_dmem  <= w_win_dmem;
            imem_gnt     <= ~w_win_dmem;
            dmem_gnt     <= w_win_dmem;
          end
        end
        S_ADDR: begin
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            bus_valid_o <= 1'b0;
            imem_done   <= ~r_owner_dmem;
            dmem_done   <= r_owner_dmem;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          // Always spend one IDLE cycle before the next grant; address stays put.
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          bus_valid_o <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_addr_ctrl.sv
// Bench for bus_addr_ctrl: a transaction-level model expands each grant into its
// expected per-cycle output waveform; directed cases pin literal values, then random stress.
module tb_bus_addr_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_done;
  logic        dmem_req;
  logic [15:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_done;
  logic [2:0]  wait_cfg;
  logic [15:0] bus_addr_o;
  logic        bus_valid_o;
  logic        busy;
  logic [1:0]  o_dbg_state;

  bus_addr_ctrl #(.ADDR_W(16), .WAIT_W(3)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_done(imem_done),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt), .dmem_done(dmem_done),
    .wait_cfg(wait_cfg), .bus_addr_o(bus_addr_o), .bus_valid_o(bus_valid_o),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Output vector: {imem_gnt, imem_done, dmem_gnt, dmem_done, valid, busy, addr}
  logic [21:0] exp_q[$];
  logic [21:0] exp_cur;
  logic [21:0] act_vec;
  logic        model_last_dmem;
  logic [15:0] model_last_addr;
  logic        prev_valid;
  logic [15:0] prev_addr;

  assign act_vec = {imem_gnt, imem_done, dmem_gnt, dmem_done, bus_valid_o, busy, bus_addr_o};

  function automatic logic [21:0] mk(input logic ig, input logic id, input logic dg,
                                     input logic dd, input logic v, input logic b,
                                     input logic [15:0] a);
    return {ig, id, dg, dd, v, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Model: when the bus is free and someone asks, schedule the whole transaction
  // (grant, hold cycles, done, mandatory idle) as a list of expected cycles.
  task automatic model_step(input logic ir, input logic [15:0] ia, input logic dr,
                            input logic [15:0] da, input logic [2:0] w);
    logic        win;
    logic [15:0] a;
    if (exp_q.size() == 0) begin
      if (ir || dr) begin
        if (ir && dr) win = !model_last_dmem;
        else          win = dr;
        a = win ? da : ia;
        exp_q.push_back(mk(!win, 1'b0, win, 1'b0, 1'b1, 1'b1, a));
        for (int k = 0; k < int'(w); k++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a));
        exp_q.push_back(mk(1'b0, !win, 1'b0, win, 1'b0, 1'b1, a));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a));
        model_last_dmem = win;
        model_last_addr = a;
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_last_addr));
      end
    end
    exp_cur = exp_q.pop_front();
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_last_dmem = 1'b0;
    model_last_addr = '0;
    exp_cur         = '0;
    prev_valid      = 1'b0;
    prev_addr       = '0;
  endtask

  // Scoreboard compare, run once per cycle away from the rising edge
  task automatic compare();
    chk("cycle_model", {10'd0, act_vec}, {10'd0, exp_cur});
    chk("gnt_onehot", {31'd0, imem_gnt & dmem_gnt}, 32'd0);
    chk("done_onehot", {31'd0, imem_done & dmem_done}, 32'd0);
    if (prev_valid && bus_valid_o) chk("addr_stable", {16'd0, bus_addr_o}, {16'd0, prev_addr});
    prev_valid = bus_valid_o;
    prev_addr  = bus_addr_o;
  endtask

  // Driver: apply inputs, advance one edge, check the new cycle
  task automatic tick(input logic ir, input logic [15:0] ia, input logic dr,
                      input logic [15:0] da, input logic [2:0] w);
    imem_req  = ir;
    imem_addr = ia;
    dmem_req  = dr;
    dmem_addr = da;
    wait_cfg  = w;
    model_step(ir, ia, dr, da, w);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  int vcnt;

  initial begin
    rst = 1'b0;
    imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_addr = '0; wait_cfg = '0;
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    compare();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_addr", {16'd0, bus_addr_o}, 32'd0);
    rst = 1'b0;

    // Tie after reset: dmem first, then imem, then dmem
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    chk("tie1_dmem_gnt", {31'd0, dmem_gnt}, 32'd1);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    chk("tie1_dmem_done", {31'd0, dmem_done}, 32'd1);
    tick(1'b1, 16'h1111, 1'b0, 16'h2222, 3'd1);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    chk("tie2_imem_gnt", {31'd0, imem_gnt}, 32'd1);
    chk("tie2_addr", {16'd0, bus_addr_o}, 32'h1111);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    tick(1'b0, 16'h1111, 1'b1, 16'h2222, 3'd1);
    tick(1'b1, 16'h1111, 1'b1, 16'h2222, 3'd1);
    chk("tie3_dmem_gnt", {31'd0, dmem_gnt}, 32'd1);
    repeat (4) tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);

    // Single request, no wait states
    tick(1'b1, 16'h1234, 1'b0, 16'h0, 3'd0);
    chk("single_gnt", {31'd0, imem_gnt}, 32'd1);
    chk("single_addr", {16'd0, bus_addr_o}, 32'h1234);
    chk("single_valid", {31'd0, bus_valid_o}, 32'd1);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    chk("single_done", {31'd0, imem_done}, 32'd1);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);

    // Wait states: valid for 6 cycles, done in cycle 7, address held after
    tick(1'b0, 16'h0, 1'b1, 16'hBEEF, 3'd5);
    chk("ws_gnt", {31'd0, dmem_gnt}, 32'd1);
    vcnt = int'(bus_valid_o);
    for (int c = 2; c <= 7; c++) begin
      tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd5);
      vcnt += int'(bus_valid_o);
      if (c == 7) chk("ws_done", {31'd0, dmem_done}, 32'd1);
    end
    chk("ws_valid_cycles", vcnt, 32'd6);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd5);
    chk("ws_addr_hold", {16'd0, bus_addr_o}, 32'hBEEF);

    // Early drop and late address / wait_cfg change
    tick(1'b1, 16'h0A0A, 1'b0, 16'h0, 3'd3);
    chk("late_gnt", {31'd0, imem_gnt}, 32'd1);
    tick(1'b1, 16'h5555, 1'b0, 16'h0, 3'd7);
    tick(1'b0, 16'h5555, 1'b0, 16'h0, 3'd7);
    tick(1'b0, 16'h5555, 1'b0, 16'h0, 3'd0);
    chk("late_not_done_yet", {31'd0, imem_done}, 32'd0);
    tick(1'b0, 16'h5555, 1'b0, 16'h0, 3'd0);
    chk("late_done", {31'd0, imem_done}, 32'd1);
    chk("late_addr", {16'd0, bus_addr_o}, 32'h0A0A);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);

    // Asynchronous reset in the middle of ADDR
    tick(1'b0, 16'h0, 1'b1, 16'hCAFE, 3'd4);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", {16'd0, bus_addr_o}, 32'd0);
    model_reset();
    @(negedge clk);
    compare();
    rst = 1'b0;
    tick(1'b1, 16'h0101, 1'b1, 16'h0202, 3'd0);
    chk("arst_tie_dmem", {31'd0, dmem_gnt}, 32'd1);
    repeat (4) tick(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);

    // Random stress
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 2) == 0), 16'($urandom_range(0, 16'hFFFF)),
           ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 16'hFFFF)),
           3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
